// File: rtl/mem_ctrl.sv
// Word-addressed synchronous memory with a fixed wait-state handshake toward the MDR.
// Optional out-of-range detection is enabled by defining MEM_RANGE_CHECK_EN.
module mem_ctrl #(
    parameter int unsigned DATA_WIDTH  = 32,
    parameter int unsigned DEPTH       = 512,
    parameter int unsigned WAIT_STATES = 2
) (
    input  logic                  clock,
    input  logic                  clear,
    input  logic                  read,
    input  logic                  write,
    input  logic [31:0]           Address,
    input  logic [DATA_WIDTH-1:0] WriteData,
    output logic [DATA_WIDTH-1:0] Mdatain,
    output logic                  mem_ready,
    output logic                  busy,
    output logic                  addr_err
);

    localparam int unsigned IW = $clog2(DEPTH);
    localparam logic [3:0] WAIT_INIT = (WAIT_STATES == 0) ? 4'd0 : 4'(WAIT_STATES - 1);

    typedef enum logic [1:0] {StIdle, StWait, StAccess, StDone} state_e;

    state_e                state;
    logic [3:0]            cnt;
    logic [IW-1:0]         idx;
    logic [DATA_WIDTH-1:0] wdata;
    logic                  op_write;
    logic                  range_bad;
    logic                  req_bad;

    logic [DATA_WIDTH-1:0] mem [DEPTH];

`ifdef MEM_RANGE_CHECK_EN
    assign req_bad = (Address >= 32'(DEPTH));
`else
    // Upper address bits are deliberately ignored so accesses alias modulo DEPTH.
    logic unused_addr;
    assign unused_addr = ^Address[31:IW];
    assign req_bad     = 1'b0;
    assign addr_err    = 1'b0;
`endif

    always_ff @(posedge clock or posedge clear) begin
        if (clear) begin
            state     <= StIdle;
            cnt       <= 4'd0;
            idx       <= '0;
            wdata     <= '0;
            op_write  <= 1'b0;
            range_bad <= 1'b0;
            Mdatain   <= '0;
            mem_ready <= 1'b0;
            busy      <= 1'b0;
`ifdef MEM_RANGE_CHECK_EN
            addr_err  <= 1'b0;
`endif
        end else begin
            unique case (state)
                StIdle: begin
                    if (read || write) begin
                        idx       <= Address[IW-1:0];
                        wdata     <= WriteData;
                        op_write  <= write;
                        range_bad <= req_bad;
                        busy      <= 1'b1;
`ifdef MEM_RANGE_CHECK_EN
                        addr_err  <= 1'b0;
`endif
                        if (WAIT_STATES == 0) begin
                            state <= StAccess;
                        end else begin
                            state <= StWait;
                            cnt   <= WAIT_INIT;
                        end
                    end
                end
                StWait: begin
                    if (cnt == 4'd0) begin
                        state <= StAccess;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                StAccess: begin
                    if (!op_write) begin
                        Mdatain <= range_bad ? '0 : mem[idx];
                    end
`ifdef MEM_RANGE_CHECK_EN
                    addr_err  <= range_bad;
`endif
                    mem_ready <= 1'b1;
                    state     <= StDone;
                end
                StDone: begin
                    mem_ready <= 1'b0;
                    busy      <= 1'b0;
                    state     <= StIdle;
                end
                default: state <= StIdle;
            endcase
        end
    end

    // Array is not reset; an asynchronous clear leaves StAccess unreachable so aborted writes drop.
    always_ff @(posedge clock) begin
        if (state == StAccess && op_write && !range_bad) begin
            mem[idx] <= wdata;
        end
    end

endmodule
